// File: rtl/core_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding and image word geometry.
package core_pkg;

    typedef enum logic [2:0] {HEADER, LOAD, WRITE, CHECK, RUN, ERROR} boot_state_e;

    localparam int unsigned BOOT_WORD_BYTES = 4;

    // Byte address of payload word idx, counted from base.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input, memory write port and core control/status of the boot loader.
interface boot_loader_if #(
    parameter int unsigned MAX_WORDS = 128
);
    localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

    logic             rx_valid_ip;
    logic [7:0]       rx_data_ip;
    logic             rx_ready_op;
    logic             mem_we_op;
    logic [31:0]      mem_addr_op;
    logic [31:0]      mem_wdata_op;
    logic             mem_gnt_ip;
    logic             core_reset_op;
    logic             core_mem_en_op;
    logic             boot_done_op;
    logic             boot_error_op;
    logic [CNT_W-1:0] words_loaded_op;

    modport master (
        input  rx_valid_ip, rx_data_ip, mem_gnt_ip,
        output rx_ready_op, mem_we_op, mem_addr_op, mem_wdata_op,
        output core_reset_op, core_mem_en_op, boot_done_op, boot_error_op, words_loaded_op
    );

    modport slave (
        output rx_valid_ip, rx_data_ip, mem_gnt_ip,
        input  rx_ready_op, mem_we_op, mem_addr_op, mem_wdata_op,
        input  core_reset_op, core_mem_en_op, boot_done_op, boot_error_op, words_loaded_op
    );

endinterface

// File: rtl/boot_byte_assembler.sv
// Packs accepted bytes little-endian into 32-bit words; flags the byte that completes a word.
module boot_byte_assembler
    import core_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_ready
);
    localparam int unsigned IDX_W = $clog2(BOOT_WORD_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BOOT_WORD_BYTES - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      word_q, word_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (byte_valid) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_data;
            idx_d = idx_q + IDX_W'(1);
        end
    end

    // The in-flight byte is merged in so the owner can consume the word on its accepting edge.
    always_comb begin
        word = word_q;
        word[{idx_q, 3'b000} +: 8] = byte_data;
    end

    assign word_ready = byte_valid && !clear && (idx_q == LAST_IDX);

    always_ff @(posedge clock) begin
        if (!reset) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Boot controller: receives a length-prefixed image, writes it to instruction memory, verifies
// the XOR checksum and then releases the core from reset.
module boot_loader
    import core_pkg::*;
#(
    parameter int unsigned MAX_WORDS        = 128,
    parameter logic [31:0] INSTR_START_ADDR = 32'h0
) (
    input  logic          clock,
    input  logic          reset,
    boot_loader_if.master bus
);
    localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

    boot_state_e      state_q, state_d;
    logic [31:0]      n_q, n_d;
    logic [31:0]      csum_q, csum_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             rx_ready_q, rx_ready_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             core_reset_q, core_reset_d;
    logic             core_mem_en_q, core_mem_en_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic        byte_valid;
    logic        asm_clear;
    logic        word_ready;
    logic [31:0] word;

    assign byte_valid = bus.rx_valid_ip && rx_ready_q;
    assign asm_clear  = (state_q == WRITE) || (state_q == RUN) || (state_q == ERROR);

    boot_byte_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_valid (byte_valid),
        .byte_data  (bus.rx_data_ip),
        .word       (word),
        .word_ready (word_ready)
    );

    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        csum_d        = csum_q;
        words_d       = words_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        core_reset_d  = core_reset_q;
        core_mem_en_d = core_mem_en_q;
        done_d        = done_q;
        error_d       = error_q;

        unique case (state_q)
            HEADER: begin
                if (word_ready) begin
                    n_d = word;
                    // Full 32-bit compare so huge headers cannot alias into range.
                    if (word > MAX_WORDS) begin
                        state_d = ERROR;
                    end else if (word == '0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (word_ready) begin
                    state_d     = WRITE;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = word_addr(INSTR_START_ADDR, 32'(words_q));
                    mem_wdata_d = word;
                end
            end
            WRITE: begin
                if (bus.mem_gnt_ip) begin
                    mem_we_d = 1'b0;
                    words_d  = words_q + CNT_W'(1);
                    csum_d   = csum_q ^ mem_wdata_q;
                    state_d  = (32'(words_q) + 32'd1 == n_q) ? CHECK : LOAD;
                end
            end
            CHECK: begin
                if (word_ready) begin
                    if (word == csum_q) begin
                        state_d       = RUN;
                        core_mem_en_d = 1'b1;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            RUN: begin
                core_mem_en_d = 1'b1;
                core_reset_d  = 1'b1;
                done_d        = 1'b1;
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = ERROR;
            end
        endcase

        if (state_d == ERROR) begin
            error_d       = 1'b1;
            core_reset_d  = 1'b0;
            core_mem_en_d = 1'b0;
            done_d        = 1'b0;
            mem_we_d      = 1'b0;
        end

        rx_ready_d = (state_d == HEADER) || (state_d == LOAD) || (state_d == CHECK);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= HEADER;
            n_q           <= '0;
            csum_q        <= '0;
            words_q       <= '0;
            rx_ready_q    <= 1'b1;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            core_reset_q  <= 1'b0;
            core_mem_en_q <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            csum_q        <= csum_d;
            words_q       <= words_d;
            rx_ready_q    <= rx_ready_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            core_reset_q  <= core_reset_d;
            core_mem_en_q <= core_mem_en_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign bus.rx_ready_op     = rx_ready_q;
    assign bus.mem_we_op       = mem_we_q;
    assign bus.mem_addr_op     = mem_addr_q;
    assign bus.mem_wdata_op    = mem_wdata_q;
    assign bus.core_reset_op   = core_reset_q;
    assign bus.core_mem_en_op  = core_mem_en_q;
    assign bus.boot_done_op    = done_q;
    assign bus.boot_error_op   = error_q;
    assign bus.words_loaded_op = words_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: table of images checked against a write scoreboard, plus hand-written
// sequences for reset state, write back-pressure and reset in the middle of a load.
module tb_boot_loader;
    localparam int unsigned MAX_WORDS = 128;
    localparam logic [31:0] BASE = 32'h0;
    localparam int NV = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    boot_loader_if #(.MAX_WORDS(MAX_WORDS)) bus ();

    boot_loader #(
        .MAX_WORDS        (MAX_WORDS),
        .INSTR_START_ADDR (BASE)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] n;
        int          nw;
        bit          gen;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] flip;
        bit          send_csum;
        bit          exp_done;
        bit          exp_error;
        int          exp_wl;
    } vec_t;

    vec_t vecs[NV];
    wr_t  exp_q[$];
    wr_t  obs_q[$];
    int   rd_idx = 0;
    int   we_cycles = 0;
    int   tests = 0;
    int   fails = 0;

    // Write monitor: records each granted write, sampled mid-cycle.
    always @(negedge clk) begin
        wr_t o;
        #2;
        if (bus.mem_we_op === 1'b1) begin
            we_cycles++;
            if (bus.mem_gnt_ip === 1'b1) begin
                o.addr = bus.mem_addr_op;
                o.data = bus.mem_wdata_op;
                obs_q.push_back(o);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        bus.rx_valid_ip = 1'b1;
        bus.rx_data_ip  = b;
        while (bus.rx_ready_op !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (bus.rx_ready_op !== 1'b1) begin
            check("rx_ready wait", 32'(bus.rx_ready_op), 32'd1);
            bus.rx_valid_ip = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.rx_valid_ip = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int k = 0; k < 4; k++) send_byte(t[8*k +: 8]);
    endtask

    task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.rx_valid_ip = 1'b0;
        bus.mem_gnt_ip  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        wr_t o;
        wr_t e;
        while (rd_idx < obs_q.size()) begin
            o = obs_q[rd_idx];
            rd_idx++;
            if (exp_q.size() == 0) begin
                check({tag, " unexpected write"}, 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check({tag, " write addr"}, o.addr, e.addr);
                check({tag, " write data"}, o.data, e.data);
            end
        end
        check({tag, " missing writes"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    function automatic vec_t mk(input logic [31:0] n, input int nw, input bit gen,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] flip,
                                input bit send_csum, input bit exp_done, input int exp_wl);
        vec_t v;
        v.n = n; v.nw = nw; v.gen = gen;
        v.w0 = w0; v.w1 = w1; v.w2 = w2; v.flip = flip;
        v.send_csum = send_csum;
        v.exp_done = exp_done; v.exp_error = !exp_done; v.exp_wl = exp_wl;
        return v;
    endfunction

    function automatic logic [31:0] vword(input vec_t v, input int i);
        if (v.gen) return 32'h9E37_79B9 * 32'(i + 1);
        case (i)
            0:       return v.w0;
            1:       return v.w1;
            default: return v.w2;
        endcase
    endfunction

    initial begin
        logic [31:0] cs;
        logic [31:0] w;
        vec_t        v;
        int          we_base;
        string       tag;

        vecs[0] = mk(32'd2, 2, 0, 32'h0000_0013, 32'h00A0_0093, 0, 0, 1, 1, 2);
        vecs[1] = mk(32'd1, 1, 0, 32'h1234_5678, 0, 0, 32'h1, 1, 0, 1);
        vecs[2] = mk(32'd0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        vecs[3] = mk(32'd129, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4] = mk(32'd3, 3, 0, 32'hDEAD_BEEF, 32'h0123_4567, 32'hFFFF_FFFF, 0, 1, 1, 3);
        vecs[5] = mk(32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[6] = mk(32'd128, 128, 1, 0, 0, 0, 0, 1, 1, 128);
        vecs[7] = mk(32'd2, 2, 0, 32'h1, 32'h2, 0, 32'h8000_0000, 1, 0, 2);

        // Reset values.
        rst_n = 1'b0;
        bus.rx_valid_ip = 1'b0;
        bus.rx_data_ip  = 8'h00;
        bus.mem_gnt_ip  = 1'b1;
        repeat (2) @(negedge clk);
        check("reset rx_ready", 32'(bus.rx_ready_op), 32'd1);
        check("reset mem_we", 32'(bus.mem_we_op), 32'd0);
        check("reset mem_addr", bus.mem_addr_op, 32'd0);
        check("reset mem_wdata", bus.mem_wdata_op, 32'd0);
        check("reset core_reset", 32'(bus.core_reset_op), 32'd0);
        check("reset core_mem_en", 32'(bus.core_mem_en_op), 32'd0);
        check("reset boot_done", 32'(bus.boot_done_op), 32'd0);
        check("reset boot_error", 32'(bus.boot_error_op), 32'd0);
        check("reset words_loaded", 32'(bus.words_loaded_op), 32'd0);
        rst_n = 1'b1;

        for (int vi = 0; vi < NV; vi++) begin
            v = vecs[vi];
            tag = $sformatf("vec%0d", vi);
            do_reset();
            we_base = we_cycles;
            cs = v.flip;
            send_word(v.n);
            for (int i = 0; i < v.nw; i++) begin
                w = vword(v, i);
                cs = cs ^ w;
                expect_write(BASE + 32'(4 * i), w);
                send_word(w);
            end
            if (v.send_csum) send_word(cs);
            // First cycle after the last accepted byte.
            @(negedge clk);
            check({tag, " error t+1"}, 32'(bus.boot_error_op), 32'(v.exp_error));
            check({tag, " core_mem_en t+1"}, 32'(bus.core_mem_en_op), 32'(v.exp_done));
            check({tag, " core_reset t+1"}, 32'(bus.core_reset_op), 32'd0);
            check({tag, " done t+1"}, 32'(bus.boot_done_op), 32'd0);
            @(negedge clk);
            check({tag, " core_reset t+2"}, 32'(bus.core_reset_op), 32'(v.exp_done));
            check({tag, " done t+2"}, 32'(bus.boot_done_op), 32'(v.exp_done));
            // Terminal state ignores further bytes.
            bus.rx_valid_ip = 1'b1;
            bus.rx_data_ip  = 8'h55;
            repeat (3) @(negedge clk);
            check({tag, " terminal rx_ready"}, 32'(bus.rx_ready_op), 32'd0);
            check({tag, " words_loaded"}, 32'(bus.words_loaded_op), 32'(v.exp_wl));
            check({tag, " core_mem_en hold"}, 32'(bus.core_mem_en_op), 32'(v.exp_done));
            bus.rx_valid_ip = 1'b0;
            drain(tag);
            check({tag, " mem_we cycles"}, 32'(we_cycles - we_base), 32'(v.exp_wl));
        end

        // Back-pressure: grant withheld for 3 cycles on the first write.
        do_reset();
        expect_write(BASE, 32'h0000_0013);
        expect_write(BASE + 32'd4, 32'h00A0_0093);
        send_word(32'd2);
        bus.mem_gnt_ip = 1'b0;
        send_word(32'h0000_0013);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d mem_we", i), 32'(bus.mem_we_op), 32'd1);
            check($sformatf("stall%0d addr", i), bus.mem_addr_op, BASE);
            check($sformatf("stall%0d data", i), bus.mem_wdata_op, 32'h0000_0013);
            check($sformatf("stall%0d rx_ready", i), 32'(bus.rx_ready_op), 32'd0);
            if (i == 3) bus.mem_gnt_ip = 1'b1;
        end
        @(negedge clk);
        check("stall rx_ready after grant", 32'(bus.rx_ready_op), 32'd1);
        check("stall mem_we after grant", 32'(bus.mem_we_op), 32'd0);
        check("stall words_loaded", 32'(bus.words_loaded_op), 32'd1);
        send_word(32'h00A0_0093);
        send_word(32'h00A0_0080);
        repeat (3) @(negedge clk);
        check("stall boot_done", 32'(bus.boot_done_op), 32'd1);
        check("stall words_loaded end", 32'(bus.words_loaded_op), 32'd2);
        drain("stall");

        // Reset in the middle of a payload word, then a fresh N=1 image.
        do_reset();
        send_word(32'd2);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset mem_we", 32'(bus.mem_we_op), 32'd0);
        check("midreset core_reset", 32'(bus.core_reset_op), 32'd0);
        check("midreset rx_ready", 32'(bus.rx_ready_op), 32'd1);
        check("midreset words_loaded", 32'(bus.words_loaded_op), 32'd0);
        rst_n = 1'b1;
        we_base = we_cycles;
        expect_write(BASE, 32'hCAFE_F00D);
        send_word(32'd1);
        send_word(32'hCAFE_F00D);
        send_word(32'hCAFE_F00D);
        repeat (3) @(negedge clk);
        check("midreset boot_done", 32'(bus.boot_done_op), 32'd1);
        check("midreset core_reset end", 32'(bus.core_reset_op), 32'd1);
        check("midreset boot_error", 32'(bus.boot_error_op), 32'd0);
        drain("midreset");
        check("midreset mem_we cycles", 32'(we_cycles - we_base), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
